// File: rtl/deconvolver.sv
// Streaming mod-16 deconvolver: loads an 8-tap kernel h, then recovers x[0..7]
// from y[0..14] by back-substitution and checks y[8..14] for consistency.
module deconvolver (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       in_valid,
   input  logic [3:0] in_data,
   output logic       in_ready,
   output logic       x_valid,
   output logic [3:0] x_data,
   output logic [2:0] x_idx,
   input  logic       x_ready,
   output logic       busy,
   output logic       done,
   output logic       err_h0,
   output logic       err_mismatch
);

   localparam int unsigned DW   = 4;
   localparam int unsigned NTAP = 8;
   localparam int unsigned IW   = 3;
   localparam int unsigned NW   = 4;
   localparam logic [NW-1:0] N_LAST = NW'(14);

   typedef enum logic [2:0] {IDLE, LOAD_H, RECV_Y, MAC, EMIT, CHECK, DONE} state_e;

   state_e          state_q, state_d;
   logic [DW-1:0]   h_q [NTAP];
   logic [DW-1:0]   h_d [NTAP];
   logic [DW-1:0]   x_q [NTAP];
   logic [DW-1:0]   x_d [NTAP];
   logic [DW-1:0]   acc_q, acc_d;
   logic [IW-1:0]   cnt_q, cnt_d;
   logic [NW-1:0]   n_q, n_d;
   logic [IW-1:0]   k_q, k_d;
   logic            in_ready_q, in_ready_d;
   logic            x_valid_q, x_valid_d;
   logic [DW-1:0]   x_data_q, x_data_d;
   logic [IW-1:0]   x_idx_q, x_idx_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            err_h0_q, err_h0_d;
   logic            err_mm_q, err_mm_d;

   logic [IW-1:0]   xi;
   logic [DW-1:0]   term;
   logic [IW-1:0]   kmax;
   logic [IW-1:0]   kstart;
   logic            accept;

   // Multiplicative inverse of an odd nibble modulo 16.
   function automatic logic [DW-1:0] inv4(input logic [DW-1:0] v);
      case (v)
         4'd1:    inv4 = 4'd1;
         4'd3:    inv4 = 4'd11;
         4'd5:    inv4 = 4'd13;
         4'd7:    inv4 = 4'd7;
         4'd9:    inv4 = 4'd9;
         4'd11:   inv4 = 4'd3;
         4'd13:   inv4 = 4'd5;
         4'd15:   inv4 = 4'd15;
         default: inv4 = 4'd0;
      endcase
   endfunction

   // Current MAC term h[k]*x[n-k] and the tap range for sample n.
   assign xi     = IW'(n_q - {1'b0, k_q});
   assign term   = DW'(h_q[k_q] * x_q[xi]);
   assign kmax   = (n_q >= NW'(7)) ? IW'(7) : n_q[IW-1:0];
   assign kstart = (n_q <= NW'(8)) ? IW'(1) : IW'(n_q - NW'(7));
   assign accept = in_valid & in_ready_q;

   always_comb begin
      state_d  = state_q;
      h_d      = h_q;
      x_d      = x_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      n_d      = n_q;
      k_d      = k_q;
      x_data_d = x_data_q;
      x_idx_d  = x_idx_q;
      err_h0_d = err_h0_q;
      err_mm_d = err_mm_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d  = LOAD_H;
               err_h0_d = 1'b0;
               err_mm_d = 1'b0;
               cnt_d    = '0;
               n_d      = '0;
               acc_d    = '0;
            end
         end
         LOAD_H: begin
            if (accept) begin
               h_d[cnt_q] = in_data;
               if (cnt_q == '0) err_h0_d = ~in_data[0];
               if (cnt_q == IW'(NTAP-1)) state_d = RECV_Y;
               else                      cnt_d   = cnt_q + IW'(1);
            end
         end
         RECV_Y: begin
            if (accept) begin
               acc_d   = in_data;
               k_d     = kstart;
               state_d = MAC;
            end
         end
         MAC: begin
            if (n_q != '0) acc_d = acc_q - term;
            // n=0 has no terms: one idle MAC cycle, then emit.
            if (n_q == '0 || k_q == kmax) begin
               if (n_q <= NW'(7)) begin
                  state_d  = EMIT;
                  x_data_d = err_h0_q ? '0 : DW'(inv4(h_q[0]) * acc_d);
                  x_idx_d  = n_q[IW-1:0];
                  x_d[n_q[IW-1:0]] = x_data_d;
               end else begin
                  state_d = CHECK;
               end
            end else begin
               k_d = k_q + IW'(1);
            end
         end
         EMIT: begin
            if (x_ready) begin
               state_d = RECV_Y;
               n_d     = n_q + NW'(1);
            end
         end
         CHECK: begin
            if (acc_q != '0 && !err_h0_q) err_mm_d = 1'b1;
            if (n_q == N_LAST) begin
               state_d = DONE;
            end else begin
               state_d = RECV_Y;
               n_d     = n_q + NW'(1);
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      in_ready_d = (state_d == LOAD_H) || (state_d == RECV_Y);
      x_valid_d  = (state_d == EMIT);
      busy_d     = (state_d != IDLE);
      done_d     = (state_d == DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         h_q        <= '{default: '0};
         x_q        <= '{default: '0};
         acc_q      <= '0;
         cnt_q      <= '0;
         n_q        <= '0;
         k_q        <= '0;
         in_ready_q <= 1'b0;
         x_valid_q  <= 1'b0;
         x_data_q   <= '0;
         x_idx_q    <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_h0_q   <= 1'b0;
         err_mm_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         h_q        <= h_d;
         x_q        <= x_d;
         acc_q      <= acc_d;
         cnt_q      <= cnt_d;
         n_q        <= n_d;
         k_q        <= k_d;
         in_ready_q <= in_ready_d;
         x_valid_q  <= x_valid_d;
         x_data_q   <= x_data_d;
         x_idx_q    <= x_idx_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_h0_q   <= err_h0_d;
         err_mm_q   <= err_mm_d;
      end
   end

   assign in_ready     = in_ready_q;
   assign x_valid      = x_valid_q;
   assign x_data       = x_data_q;
   assign x_idx        = x_idx_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign err_h0       = err_h0_q;
   assign err_mismatch = err_mm_q;

endmodule
